// File: rtl/network_receive_desc_pkg.sv
// Shared types and constants for the receive descriptor aggregator.
// Arbiter states, destination codes and a constant-width helper.
package network_receive_desc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } arb_state_t;

    localparam logic DEST_HOST    = 1'b0;
    localparam logic DEST_NETWORK = 1'b1;
    localparam int   INPORT_W     = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/desc_sync_fifo.sv
// Show-ahead synchronous FIFO holding {dest, descriptor} per port.
// Pointers carry one extra wrap bit to tell full from empty.
module desc_sync_fifo
    import network_receive_desc_pkg::*;
#(
    parameter int WIDTH = 58,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/network_receive_desc_arbiter.sv
// N-port receive descriptor aggregator: per-port FIFOs merged
// round-robin onto one tagged output with dest-matched ack/timeout.
module network_receive_desc_arbiter
    import network_receive_desc_pkg::*;
#(
    parameter int PORT_NUM    = 4,
    parameter int DESC_W      = 57,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic [PORT_NUM-1:0]        i_descriptor_wr_tohost,
    input  logic [PORT_NUM-1:0]        i_descriptor_wr_tonetwork,
    input  logic [PORT_NUM*DESC_W-1:0] iv_descriptor,
    output logic [PORT_NUM-1:0]        o_descriptor_ack,
    output logic                       o_descriptor_wr_tohost,
    output logic                       o_descriptor_wr_tonetwork,
    output logic [DESC_W-1:0]          ov_descriptor,
    output logic [INPORT_W-1:0]        ov_descriptor_inport,
    input  logic                       i_descriptor_ack_host,
    input  logic                       i_descriptor_ack_network,
    output logic                       o_dest_conflict_pulse,
    output logic                       o_ack_timeout_pulse,
    output logic [PORT_NUM-1:0]        ov_fifo_full,
    output logic [PORT_NUM-1:0]        ov_fifo_empty,
    output logic [1:0]                 ov_arb_state
);

    localparam int          TW      = clog2(ACK_TIMEOUT + 2);
    localparam int unsigned TO_LAST =
        (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;

    arb_state_t          state;
    logic [PORT_NUM-1:0] req;
    logic [PORT_NUM-1:0] accept;
    logic [PORT_NUM-1:0] pop;
    logic [PORT_NUM-1:0] avail;
    logic [DESC_W:0]     fifo_dout [PORT_NUM];
    logic [DESC_W:0]     sel_dout;
    logic [DESC_W:0]     hold;
    logic [INPORT_W-1:0] hold_port;
    logic [INPORT_W-1:0] rr_ptr;
    logic [INPORT_W-1:0] grant;
    logic                grant_vld;
    logic [TW-1:0]       to_cnt;
    logic                ack_match;
    int                  idx;

    assign req    = i_descriptor_wr_tohost | i_descriptor_wr_tonetwork;
    assign accept = req & ~ov_fifo_full & ~o_descriptor_ack;
    assign ov_arb_state = state;

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_port
        logic dest;
        assign dest = i_descriptor_wr_tonetwork[i] &
                      ~i_descriptor_wr_tohost[i];
        desc_sync_fifo #(
            .WIDTH (DESC_W + 1),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk_sys),
            .rst   (reset),
            .push  (accept[i]),
            .pop   (pop[i]),
            .din   ({dest, iv_descriptor[i*DESC_W +: DESC_W]}),
            .dout  (fifo_dout[i]),
            .full  (ov_fifo_full[i]),
            .empty (ov_fifo_empty[i])
        );
    end

    // Search starts one past the last granted port.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        sel_dout  = '0;
        idx       = 0;
        pop       = '0;
        for (int k = 1; k <= PORT_NUM; k++) begin
            idx = (int'(rr_ptr) + k) % PORT_NUM;
            if (!grant_vld && avail[idx]) begin
                grant_vld = 1'b1;
                grant     = INPORT_W'(idx);
            end
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            if (grant == INPORT_W'(i)) sel_dout = fifo_dout[i];
            pop[i] = (state == IDLE) && grant_vld &&
                     (grant == INPORT_W'(i));
        end
    end

    assign ack_match =
        (o_descriptor_wr_tohost    && i_descriptor_ack_host) ||
        (o_descriptor_wr_tonetwork && i_descriptor_ack_network);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            o_descriptor_ack      <= '0;
            o_dest_conflict_pulse <= 1'b0;
        end else begin
            o_descriptor_ack      <= accept;
            o_dest_conflict_pulse <= |(accept &
                i_descriptor_wr_tohost & i_descriptor_wr_tonetwork);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state                     <= IDLE;
            rr_ptr                    <= INPORT_W'(PORT_NUM - 1);
            avail                     <= '0;
            hold                      <= '0;
            hold_port                 <= '0;
            to_cnt                    <= '0;
            ov_descriptor             <= '0;
            ov_descriptor_inport      <= '0;
            o_descriptor_wr_tohost    <= 1'b0;
            o_descriptor_wr_tonetwork <= 1'b0;
            o_ack_timeout_pulse       <= 1'b0;
        end else begin
            avail               <= ~ov_fifo_empty;
            o_ack_timeout_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_vld) begin
                        hold      <= sel_dout;
                        hold_port <= grant;
                        rr_ptr    <= grant;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    ov_descriptor             <= hold[DESC_W-1:0];
                    ov_descriptor_inport      <= hold_port;
                    o_descriptor_wr_tohost    <= hold[DESC_W] == DEST_HOST;
                    o_descriptor_wr_tonetwork <= hold[DESC_W] == DEST_NETWORK;
                    to_cnt                    <= '0;
                    state                     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ack_match) begin
                        o_descriptor_wr_tohost    <= 1'b0;
                        o_descriptor_wr_tonetwork <= 1'b0;
                        state                     <= IDLE;
                    end else if (ACK_TIMEOUT != 0 &&
                                 to_cnt == TW'(TO_LAST)) begin
                        o_descriptor_wr_tohost    <= 1'b0;
                        o_descriptor_wr_tonetwork <= 1'b0;
                        o_ack_timeout_pulse       <= 1'b1;
                        state                     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
